// File: rtl/tdm_demux2_pkg.sv
// Shared definitions for the two-slot TDM demultiplexer: default slot width
// and the frame-tracking state encoding.
package tdm_demux2_pkg;

  localparam int DefaultWidth = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    HAVE0 = 1'b1
  } demuxState_t;

endpackage

// File: rtl/tdm_demux2_counter8.sv
// Eight-bit frame counter with async reset and enable; wraps 255 -> 0 silently.
module counter8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] count
);

  // Natural 8-bit overflow provides the modulo-256 wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: splits a shared beat stream into slot-0/slot-1
// registers, flags framing errors and counts completed frames.
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sof,
  input  logic             err_clear,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid0,
  output logic             valid1,
  output logic             pair_valid,
  output logic             sel,
  output logic             frame_err,
  output logic [7:0]       frame_count
);

  demuxState_t state;
  logic        frameDone;
  logic        framingError;

  assign frameDone    = in_valid && (state == HAVE0) && !sof;
  assign framingError = in_valid && (((state == IDLE) && !sof) || ((state == HAVE0) && sof));
  assign sel          = (state == HAVE0);

  // A fresh sof while already holding slot 0 restarts the frame rather than
  // dropping it, so the newest slot-0 data pairs with the next slot-1 beat.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      out0       <= '0;
      out1       <= '0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      pair_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      pair_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (sof) begin
              out0   <= in;
              valid0 <= 1'b1;
              state  <= HAVE0;
            end
          end
          HAVE0: begin
            if (sof) begin
              out0   <= in;
              valid0 <= 1'b1;
            end else begin
              out1       <= in;
              valid1     <= 1'b1;
              pair_valid <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (framingError) begin
        frame_err <= 1'b1;
      end else if (err_clear) begin
        frame_err <= 1'b0;
      end
    end
  end

  counter8 frameCounter (
    .clock  (Clk),
    .reset  (Reset),
    .enable (frameDone),
    .count  (frame_count)
  );

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed self-checking bench for tdm_demux2 with hand-computed expectations.
module tb_tdm_demux2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] in;
  logic       in_valid;
  logic       sof;
  logic       err_clear;
  logic [7:0] out0;
  logic [7:0] out1;
  logic       valid0;
  logic       valid1;
  logic       pair_valid;
  logic       sel;
  logic       frame_err;
  logic [7:0] frame_count;

  int testsRun = 0;
  int testsFailed = 0;
  int pairCount;

  always #5 Clk = ~Clk;

  tdm_demux2 #(.WIDTH(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .in          (in),
    .in_valid    (in_valid),
    .sof         (sof),
    .err_clear   (err_clear),
    .out0        (out0),
    .out1        (out1),
    .valid0      (valid0),
    .valid1      (valid1),
    .pair_valid  (pair_valid),
    .sel         (sel),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs are stable 1ns after the next rising edge.
  task automatic applyStimulus(input logic [7:0] data, input logic valid,
                               input logic start, input logic clear);
    @(negedge Clk);
    in        = data;
    in_valid  = valid;
    sof       = start;
    err_clear = clear;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    in = '0; in_valid = 1'b0; sof = 1'b0; err_clear = 1'b0;
    #12;
    checkOutput("reset out0", out0, 0);
    checkOutput("reset out1", out1, 0);
    checkOutput("reset sel", sel, 0);
    checkOutput("reset pulses", {valid0, valid1, pair_valid}, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset frame_count", frame_count, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Basic frame
    applyStimulus(8'hA5, 1, 1, 0);
    checkOutput("f1 out0", out0, 8'hA5);
    checkOutput("f1 valid0", valid0, 1);
    checkOutput("f1 sel", sel, 1);
    checkOutput("f1 no pair", pair_valid, 0);
    applyStimulus(8'h3C, 1, 0, 0);
    checkOutput("f1 out1", out1, 8'h3C);
    checkOutput("f1 valid1/pair", {valid0, valid1, pair_valid}, 3'b011);
    checkOutput("f1 count", frame_count, 1);
    checkOutput("f1 err", frame_err, 0);
    checkOutput("f1 sel back", sel, 0);
    applyStimulus(8'hFF, 0, 1, 0);
    checkOutput("idle pulses low", {valid0, valid1, pair_valid}, 0);
    checkOutput("idle out0 held", out0, 8'hA5);
    checkOutput("idle sel", sel, 0);

    // Stray beat in IDLE, then clear
    applyStimulus(8'h11, 1, 0, 0);
    checkOutput("stray err", frame_err, 1);
    checkOutput("stray out0", out0, 8'hA5);
    checkOutput("stray out1", out1, 8'h3C);
    checkOutput("stray sel", sel, 0);
    checkOutput("stray pulses", {valid0, valid1, pair_valid}, 0);
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("clear err", frame_err, 0);

    // Repeated sof restarts the frame
    pairCount = 0;
    applyStimulus(8'h01, 1, 1, 0);
    pairCount += int'(pair_valid);
    applyStimulus(8'h02, 1, 1, 0);
    pairCount += int'(pair_valid);
    checkOutput("resof err", frame_err, 1);
    checkOutput("resof out0", out0, 8'h02);
    checkOutput("resof valid0", valid0, 1);
    checkOutput("resof sel", sel, 1);
    checkOutput("resof count", frame_count, 1);
    applyStimulus(8'h03, 1, 0, 0);
    pairCount += int'(pair_valid);
    checkOutput("resof out1", out1, 8'h03);
    checkOutput("resof pairs", pairCount, 1);
    checkOutput("resof count+1", frame_count, 2);

    // Wrap test from a clean reset
    @(negedge Clk);
    Reset = 1'b1;
    in_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    pairCount = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 1, 1, 0);
      applyStimulus(8'(~i), 1, 0, 0);
      pairCount += int'(pair_valid);
      if (i == 254) checkOutput("wrap count 255", frame_count, 255);
    end
    checkOutput("wrap count 0", frame_count, 0);
    checkOutput("wrap pairs", pairCount, 256);
    checkOutput("wrap err", frame_err, 0);
    checkOutput("wrap last out1", out1, 8'h00);

    // Reset mid-frame abandons slot 0
    applyStimulus(8'h55, 1, 1, 0);
    checkOutput("mid sel", sel, 1);
    @(negedge Clk);
    in_valid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("async out0", out0, 0);
    checkOutput("async out1", out1, 0);
    checkOutput("async sel", sel, 0);
    checkOutput("async count", frame_count, 0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(8'h66, 1, 0, 0);
    checkOutput("post-reset err", frame_err, 1);
    checkOutput("post-reset no pair", pair_valid, 0);
    checkOutput("post-reset out1", out1, 0);

    // Error set wins over clear
    applyStimulus(8'h00, 0, 0, 1);
    checkOutput("pre clear", frame_err, 0);
    applyStimulus(8'h77, 1, 0, 1);
    checkOutput("set wins", frame_err, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/tdm_demux2.md
TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 Parameter WIDTH, default 8, data width of each slot.
REQ-002 Clk  input  1  rising-edge clock, only clock in the block.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 in  input  WIDTH  shared time-multiplexed data line.
REQ-005 in_valid  input  1  beat on `in` is present this cycle.
REQ-006 sof  input  1  start of frame; qualifies the beat as slot 0; ignored when in_valid=0.
REQ-007 err_clear  input  1  clears the sticky framing error.
REQ-008 out0  output  WIDTH  last captured slot-0 data.
REQ-009 out1  output  WIDTH  last captured slot-1 data.
REQ-010 valid0  output  1  one-cycle pulse: out0 updated.
REQ-011 valid1  output  1  one-cycle pulse: out1 updated.
REQ-012 pair_valid  output  1  one-cycle pulse: out0/out1 form a complete frame.
REQ-013 sel  output  1  slot expected next (0 = slot 0, 1 = slot 1).
REQ-014 frame_err  output  1  sticky framing-error flag.
REQ-015 frame_count  output  8  count of completed frames, modulo 256.

Function
REQ-016 The FSM SHALL have two states, IDLE (expecting slot 0) and HAVE0 (slot 0 captured, expecting slot 1).
REQ-017 sel SHALL be 0 in IDLE and 1 in HAVE0.
REQ-018 IDLE, in_valid=1, sof=1: capture in into out0, pulse valid0, go to HAVE0.
REQ-019 IDLE, in_valid=1, sof=0: discard beat, set frame_err, stay in IDLE, leave out0 and out1 unchanged.
REQ-020 HAVE0, in_valid=1, sof=0: capture in into out1, pulse valid1 and pair_valid, increment frame_count, go to IDLE.
REQ-021 HAVE0, in_valid=1, sof=1: set frame_err, capture in into out0 as a new slot 0, pulse valid0, stay in HAVE0, no pair_valid, no count change.
REQ-022 in_valid=0: no state, data or count change; all pulses are 0.
REQ-023 All outputs SHALL be registered, with the update visible one cycle after the capturing edge (latency 1 cycle).
REQ-024 valid0, valid1 and pair_valid SHALL be high for exactly one cycle per qualifying beat.
REQ-025 Back-to-back beats on consecutive cycles SHALL be accepted with no bubble; throughput is one beat per cycle.
REQ-026 frame_count SHALL wrap from 255 to 0 without flagging an error.
REQ-027 err_clear=1 SHALL clear frame_err on the next edge.
REQ-028 If an error condition and err_clear coincide, frame_err SHALL be 1 (set wins).
REQ-029 The block has no backpressure; every valid beat is consumed in its cycle.

Reset
REQ-030 Reset=1 SHALL immediately force: state IDLE, sel=0, out0=0, out1=0, valid0=0, valid1=0, pair_valid=0, frame_err=0, frame_count=0.
REQ-031 Reset asserted while in HAVE0 SHALL abandon the partial frame; the next frame requires sof.
REQ-032 The first edge after Reset deasserts SHALL process inputs normally.

Structure
REQ-033 State encodings (IDLE=0, HAVE0=1) and the default WIDTH SHALL live in the shared lab package/include file.
REQ-034 The block SHALL be a single module; the frame counter MAY be a sub-module named counter8 with async reset, enable and wrap.

Verification
REQ-035 Reset, then beats (0xA5,sof=1),(0x3C,sof=0) -> out0=0xA5, valid0 pulse; next cycle out1=0x3C, valid1 and pair_valid pulse, frame_count=1, frame_err=0.
REQ-036 From IDLE, beat (0x11,sof=0) -> frame_err=1, out0/out1 unchanged, sel=0; then err_clear=1 -> frame_err=0.
REQ-037 Beats (0x01,sof=1),(0x02,sof=1),(0x03,sof=0) -> frame_err=1, out0=0x02, out1=0x03, exactly one pair_valid, frame_count+1.
REQ-038 256 complete frames back to back -> frame_count returns to 0, 256 pair_valid pulses, frame_err=0.
REQ-039 Beat (0x55,sof=1), then Reset pulse mid-cycle, then (0x66,sof=0) -> outputs 0 immediately on Reset, then frame_err=1 and no pair_valid.
REQ-040 Stray beat in IDLE with err_clear=1 on the same cycle -> frame_err=1.
